// File: rtl/ula_pkg.sv
// Shared ULA opcode constants, flag bit positions and result/flag record types.
package ula_pkg;

  localparam logic [4:0] ULA_OP_ADD    = 5'b00000;
  localparam logic [4:0] ULA_OP_ADDINC = 5'b00001;
  localparam logic [4:0] ULA_OP_INC    = 5'b00011;
  localparam logic [4:0] ULA_OP_SUBDEC = 5'b00100;

  localparam int unsigned FLAG_O = 3;
  localparam int unsigned FLAG_S = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_Z = 0;

  localparam int unsigned ULA_DATA_W = 32;
  localparam int unsigned ULA_REG_AW = 5;
  localparam int unsigned ULA_OP_W   = 5;

  typedef struct packed {
    logic o;
    logic s;
    logic c;
    logic z;
  } ula_flags_t;

  typedef struct packed {
    logic [ULA_DATA_W-1:0] data;
    logic [ULA_REG_AW-1:0] addr;
    logic                  we;
    logic [ULA_OP_W-1:0]   op;
  } ula_res_t;

endpackage

// File: rtl/ula_result_fifo.sv
// Generic DEPTH-entry FIFO with occupancy count, synchronous flush and async active-low reset.
module ula_result_fifo #(
  parameter int unsigned WIDTH = 43,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Empty FIFO presents zeros so the head never shows stale or uninitialised storage.
  assign rdata_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/ula_result_stage.sv
// ULA result stage: buffers results for register-file writeback and holds the architectural flags.
module ula_result_stage
  import ula_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] RESU,
  input  logic              O,
  input  logic              C,
  input  logic              S,
  input  logic              Z,
  input  logic [4:0]        OP,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              rd_we,
  input  logic [3:0]        flag_mask,
  input  logic              flush,
  input  logic              clr_sticky,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_AW-1:0] wb_addr,
  output logic              wb_we,
  output logic [4:0]        wb_op,
  output logic [3:0]        FLAGS,
  output logic              ovf_sticky
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  // Same layout as ula_res_t, but sized from this instance's parameters.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] addr;
    logic              we;
    logic [4:0]        op;
  } res_t;

  res_t          in_ent;
  res_t          head;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  ula_flags_t    in_flags;
  ula_flags_t    flags_q, flags_d;
  logic          sticky_q, sticky_d;

  assign in_ready = (count < CW'(DEPTH));
  assign wb_valid = (count != '0);
  assign push     = in_valid && in_ready && !flush;
  assign pop      = wb_valid && wb_ready && !flush;

  assign in_ent   = '{data: RESU, addr: rd_addr, we: rd_we, op: OP};
  assign in_flags = '{o: O, s: S, c: C, z: Z};

  ula_result_fifo #(
    .WIDTH ($bits(res_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (in_ent),
    .rdata_o (head),
    .count_o (count)
  );

  // Flags commit at push time so they follow program order regardless of writeback stalls.
  always_comb begin
    flags_d  = flags_q;
    sticky_d = sticky_q;
    if (push) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (flag_mask[i]) flags_d[i] = in_flags[i];
      end
    end
    if (clr_sticky) sticky_d = 1'b0;
    if (push && O && flag_mask[FLAG_O]) sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
    end
  end

  assign FLAGS      = flags_q;
  assign ovf_sticky = sticky_q;
  assign wb_data    = head.data;
  assign wb_addr    = head.addr;
  assign wb_op      = head.op;
  assign wb_we      = head.we && (head.addr != '0);

endmodule

// File: tb/tb_ula_result_stage.sv
// Scoreboard bench for ula_result_stage: directed pushes queue expected writebacks, a monitor checks pops.
module tb_ula_result_stage;
  import ula_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] RESU;
  logic        O, C, S, Z;
  logic [4:0]  OP;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic [3:0]  flag_mask;
  logic        flush, clr_sticky;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        wb_we;
  logic [4:0]  wb_op;
  logic [3:0]  FLAGS;
  logic        ovf_sticky;

  always #5 clk = ~clk;

  ula_result_stage #(.DATA_W(32), .REG_AW(5), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .RESU(RESU), .O(O), .C(C), .S(S), .Z(Z), .OP(OP),
    .rd_addr(rd_addr), .rd_we(rd_we), .flag_mask(flag_mask),
    .flush(flush), .clr_sticky(clr_sticky),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_addr(wb_addr), .wb_we(wb_we), .wb_op(wb_op),
    .FLAGS(FLAGS), .ovf_sticky(ovf_sticky)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        we;
    logic [4:0]  op;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [3:0] m_flags = 4'b0000;
  logic       m_sticky = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted writeback must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && wb_valid && wb_ready && !flush) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'(wb_data), 64'hDEAD_0000);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_data", 64'(wb_data), 64'(e.data));
        check("wb_addr", 64'(wb_addr), 64'(e.addr));
        check("wb_we",   64'(wb_we),   64'(e.we));
        check("wb_op",   64'(wb_op),   64'(e.op));
      end
    end
  end

  // Called at posedge+1; returns at the posedge+1 after the push is accepted (or times out).
  task automatic push(input logic [31:0] d, input logic [4:0] a, input logic we,
                      input logic [4:0] op, input logic [3:0] fl, input logic [3:0] mask);
    int n = 0;
    in_valid = 1'b1; RESU = d; rd_addr = a; rd_we = we; OP = op;
    {O, S, C, Z} = fl; flag_mask = mask;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("push_timeout", 64'(in_ready), 64'd1);
    end else if (!flush) begin
      sb.push_back('{data: d, addr: a, we: we && (a != 5'd0), op: op});
      for (int i = 0; i < 4; i++) if (mask[i]) m_flags[i] = fl[i];
      if (fl[3] && mask[3]) m_sticky = 1'b1;
      else if (clr_sticky) m_sticky = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    rst_n = 1'b0; in_valid = 1'b0; RESU = '0; {O, S, C, Z} = 4'b0000; OP = '0;
    rd_addr = '0; rd_we = 1'b0; flag_mask = '0; flush = 1'b0; clr_sticky = 1'b0;
    wb_ready = 1'b1;
    #2;
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_flags",    64'(FLAGS),    64'd0);
    check("rst_wb_data",  64'(wb_data),  64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: first push sets FLAGS to 0001
    push(32'd0, 5'd3, 1'b1, ULA_OP_ADD, 4'b0001, 4'b1111);
    check("t1_flags", 64'(FLAGS), 64'b0001);
    idle(3);

    // 2: fill under backpressure, then release in order
    wb_ready = 1'b0;
    push(32'd3, 5'd1, 1'b1, ULA_OP_INC, 4'b0000, 4'b0000);
    push(32'd5, 5'd2, 1'b1, ULA_OP_ADDINC, 4'b0000, 4'b0000);
    check("t2_full_in_ready", 64'(in_ready), 64'd0);
    held = wb_data;
    idle(1);
    check("t2_hold_data", 64'(wb_data), 64'd3);
    check("t2_hold_valid", 64'(wb_valid), 64'd1);
    fork
      push(32'd9, 5'd3, 1'b1, ULA_OP_SUBDEC, 4'b0000, 4'b0000);
      begin idle(2); wb_ready = 1'b1; end
    join
    idle(4);
    check("t2_drained", 64'(sb.size()), 64'd0);

    // 3: ten back-to-back results with concurrent push/pop at count=1
    for (int i = 0; i < 10; i++) begin
      push(32'd100 + 32'(i), 5'(i + 1), 1'b1, (i % 2 == 0) ? ULA_OP_ADD : ULA_OP_INC,
           4'b0000, 4'b0000);
      if (i > 0) begin
        check("t3_in_ready", 64'(in_ready), 64'd1);
        check("t3_valid",    64'(wb_valid), 64'd1);
      end
    end
    idle(4);
    check("t3_drained", 64'(sb.size()), 64'd0);

    // 4: overflow flag and sticky behaviour
    push(32'd11, 5'd4, 1'b1, ULA_OP_ADD, 4'b1000, 4'b1000);
    check("t4_flags",  64'(FLAGS), 64'b1001);
    check("t4_sticky", 64'(ovf_sticky), 64'd1);
    push(32'd12, 5'd4, 1'b1, ULA_OP_ADD, 4'b0000, 4'b0000);
    check("t4_flags_keep", 64'(FLAGS), 64'b1001);
    clr_sticky = 1'b1;
    idle(1);
    clr_sticky = 1'b0; m_sticky = 1'b0;
    check("t4_sticky_clr", 64'(ovf_sticky), 64'd0);
    clr_sticky = 1'b1;
    push(32'd13, 5'd4, 1'b1, ULA_OP_ADD, 4'b1000, 4'b1000);
    clr_sticky = 1'b0;
    check("t4_sticky_setwins", 64'(ovf_sticky), 64'd1);
    check("t4_model_flags", 64'(FLAGS), 64'(m_flags));
    idle(3);

    // 5: flush discards queue and concurrent push, flags retained
    wb_ready = 1'b0;
    push(32'd21, 5'd5, 1'b1, ULA_OP_ADD, 4'b0000, 4'b0001);
    push(32'd22, 5'd6, 1'b1, ULA_OP_ADD, 4'b0000, 4'b0001);
    check("t5_flags_pre", 64'(FLAGS), 64'b1000);
    flush = 1'b1;
    wb_ready = 1'b1;
    push(32'd23, 5'd7, 1'b1, ULA_OP_ADD, 4'b0001, 4'b0001);
    flush = 1'b0;
    sb.delete();
    check("t5_valid",  64'(wb_valid),   64'd0);
    check("t5_ready",  64'(in_ready),   64'd1);
    check("t5_flags",  64'(FLAGS),      64'b1000);
    check("t5_sticky", 64'(ovf_sticky), 64'd1);
    idle(2);

    // 6: r0 destination suppresses write; async reset mid-stall
    wb_ready = 1'b0;
    push(32'd7, 5'd0, 1'b1, ULA_OP_ADD, 4'b0000, 4'b0000);
    check("t6_valid", 64'(wb_valid), 64'd1);
    check("t6_we",    64'(wb_we),    64'd0);
    check("t6_data",  64'(wb_data),  64'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(wb_valid), 64'd0);
    check("t6_rst_ready", 64'(in_ready), 64'd1);
    check("t6_rst_data",  64'(wb_data),  64'd0);
    check("t6_rst_flags", 64'(FLAGS),    64'd0);
    check("t6_rst_sticky", 64'(ovf_sticky), 64'd0);
    sb.delete(); m_flags = 4'b0000; m_sticky = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wb_ready = 1'b1;
    push(32'hCAFE, 5'd9, 1'b1, ULA_OP_INC, 4'b0100, 4'b0100);
    check("t6_recover_flags", 64'(FLAGS), 64'b0100);
    idle(4);
    check("final_drained", 64'(sb.size()), 64'd0);
    if (held !== 32'd3) check("t2_held_sample", 64'(held), 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
